// File: rtl/io_bridge.sv
// io_bridge: splits CPU data accesses between the data RAM (zero-cycle
// pass-through) and the I/O bus (multi-cycle handshake, CPU stalled).
// Optional feature macro: IO_BRIDGE_TIMEOUT_EN adds a wait counter that
// aborts an I/O access after TIMEOUT_CYCLES and raises a sticky bus_error.

`ifndef IO_ADDR_WIDTH
`define IO_ADDR_WIDTH 8
`endif
`ifndef IO_DATA_WIDTH
`define IO_DATA_WIDTH 8
`endif

module io_bridge #(
  parameter logic [31:0] IO_BASE        = 32'hFFFF_FF00,
  parameter int          IO_ADDR_WIDTH  = `IO_ADDR_WIDTH,
  parameter int          IO_DATA_WIDTH  = `IO_DATA_WIDTH,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_read,
  input  logic                     cpu_write,
  input  logic [31:0]              cpu_addr,
  input  logic [31:0]              cpu_wdata,
  output logic [31:0]              cpu_rdata,
  output logic                     cpu_stall,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata,
  output logic                     io_read,
  output logic                     io_write,
  output logic [IO_ADDR_WIDTH-1:0] io_addr,
  inout  wire  [IO_DATA_WIDTH-1:0] io_data,
  input  logic                     io_ready,
  output logic                     bus_error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t                   state;
  state_t                   state_n;
  logic                     addr_hit;
  logic                     io_hit;
  logic                     timeout_hit;
  logic [IO_ADDR_WIDTH-1:0] addr_q;
  logic                     wr_q;
  logic [IO_DATA_WIDTH-1:0] wdata_q;
  logic [31:0]              rd_q;

  // Reject parameter sets the datapath cannot represent.
  if (IO_DATA_WIDTH > 32 || IO_DATA_WIDTH < 1 || IO_ADDR_WIDTH >= 32 ||
      IO_ADDR_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("io_bridge: unsupported parameter combination");
  end

  assign addr_hit = (cpu_addr[31:IO_ADDR_WIDTH] == IO_BASE[31:IO_ADDR_WIDTH]);
  assign io_hit   = addr_hit && (cpu_read || cpu_write);

  // RAM side is purely combinational; a simultaneous read+write is a write.
  assign mem_read  = cpu_read && !cpu_write && !addr_hit;
  assign mem_write = cpu_write && !addr_hit;
  assign mem_addr  = cpu_addr;
  assign mem_wdata = cpu_wdata;

  assign io_addr = addr_q;
  // The bridge only owns the bus while a write strobe is up.
  assign io_data = io_write ? wdata_q : {IO_DATA_WIDTH{1'bz}};

  // State register; async reset so strobes drop the moment rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // Next-state decode plus CPU/I/O handshake outputs.
  always_comb begin
    state_n   = state;
    cpu_stall = 1'b0;
    io_read   = 1'b0;
    io_write  = 1'b0;
    cpu_rdata = rd_q;
    case (state)
      S_IDLE: begin
        cpu_rdata = mem_rdata;
        if (io_hit) begin
          cpu_stall = 1'b1;
          state_n   = S_ACCESS;
        end
      end
      S_ACCESS: begin
        cpu_stall = 1'b1;
        io_write  = wr_q;
        io_read   = !wr_q;
        if (io_ready || timeout_hit) state_n = S_DONE;
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Request latch in IDLE and read-data capture in ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rd_q    <= '0;
    end else begin
      if (state == S_IDLE && io_hit) begin
        addr_q  <= cpu_addr[IO_ADDR_WIDTH-1:0] - IO_BASE[IO_ADDR_WIDTH-1:0];
        wr_q    <= cpu_write;
        wdata_q <= cpu_wdata[IO_DATA_WIDTH-1:0];
      end
      if (state == S_ACCESS) begin
        if (io_ready) begin
          if (!wr_q) rd_q <= 32'(io_data);
        end else if (timeout_hit) begin
          rd_q <= 32'hFFFF_FFFF;
        end
      end
    end
  end

`ifdef IO_BRIDGE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             bus_error_q;

  // The last permitted wait cycle is the one where the counter shows TIMEOUT_CYCLES-1.
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign bus_error   = bus_error_q;

  // Wait counter and sticky error flag; only reset clears the flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      bus_error_q <= 1'b0;
    end else begin
      if (state == S_IDLE && io_hit) begin
        wait_cnt <= '0;
      end else if (state == S_ACCESS && !io_ready) begin
        if (timeout_hit) bus_error_q <= 1'b1;
        else             wait_cnt    <= wait_cnt + 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign bus_error   = 1'b0;
`endif

endmodule

// File: tb/tb_io_bridge.sv
// Directed bench for io_bridge: RAM pass-through, I/O write/read handshakes,
// wait states, simultaneous read+write, async reset mid-access, and the
// timeout path when IO_BRIDGE_TIMEOUT_EN is defined.

module tb_io_bridge;

  localparam int AW = 8;
  localparam int DW = 8;
`ifdef IO_BRIDGE_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_read, cpu_write;
  logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          mem_read, mem_write;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic          io_read, io_write;
  logic [AW-1:0] io_addr;
  wire  [DW-1:0] io_data;
  logic          io_ready;
  logic          bus_error;
  logic          slave_drv;
  logic [DW-1:0] slave_val;

  int n_chk = 0;
  int n_bad = 0;

  assign io_data = slave_drv ? slave_val : {DW{1'bz}};

  io_bridge #(
    .IO_BASE       (32'hFFFF_FF00),
    .IO_ADDR_WIDTH (AW),
    .IO_DATA_WIDTH (DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_read (cpu_read),
    .cpu_write(cpu_write),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .mem_read (mem_read),
    .mem_write(mem_write),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .io_read  (io_read),
    .io_write (io_write),
    .io_addr  (io_addr),
    .io_data  (io_data),
    .io_ready (io_ready),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    io_ready  = 1'b0;
    slave_drv = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    cpu_addr  = '0;
    cpu_wdata = '0;
    mem_rdata = 32'hDEAD_BEEF;
    slave_val = '0;
    idle();
    #12;
    chk("rst_io_read",   32'(io_read),   0);
    chk("rst_io_write",  32'(io_write),  0);
    chk("rst_io_addr",   32'(io_addr),   0);
    chk("rst_stall",     32'(cpu_stall), 0);
    chk("rst_bus_error", 32'(bus_error), 0);
    chk("rst_rdata",     cpu_rdata,      32'hDEAD_BEEF);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // RAM store
    cpu_write = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'hA5; #1;
    chk("ram_st_memw",  32'(mem_write), 1);
    chk("ram_st_memr",  32'(mem_read),  0);
    chk("ram_st_addr",  mem_addr,       32'h100);
    chk("ram_st_wdata", mem_wdata,      32'hA5);
    chk("ram_st_stall", 32'(cpu_stall), 0);
    chk("ram_st_iow",   32'(io_write),  0);
    tick();
    chk("ram_st_iow2",  32'(io_write),  0);

    // RAM load just below the I/O window
    cpu_write = 1'b0; cpu_read = 1'b1; cpu_addr = 32'hFFFF_FEFF;
    mem_rdata = 32'h1234_5678; #1;
    chk("ram_ld_memr",  32'(mem_read),  1);
    chk("ram_ld_addr",  mem_addr,       32'hFFFF_FEFF);
    chk("ram_ld_rdata", cpu_rdata,      32'h1234_5678);
    chk("ram_ld_stall", 32'(cpu_stall), 0);
    chk("ram_ld_ior",   32'(io_read),   0);
    tick();
    idle();

    // I/O write, ready in the first ACCESS cycle
    cpu_write = 1'b1; cpu_addr = 32'hFFFF_FF80; cpu_wdata = 32'h1FF; io_ready = 1'b1; #1;
    chk("wr_req_stall", 32'(cpu_stall), 1);
    chk("wr_req_memw",  32'(mem_write), 0);
    chk("wr_req_iow",   32'(io_write),  0);
    tick();
    chk("wr_acc_iow",   32'(io_write),  1);
    chk("wr_acc_ior",   32'(io_read),   0);
    chk("wr_acc_addr",  32'(io_addr),   32'h80);
    chk("wr_acc_data",  32'(io_data),   32'hFF);
    chk("wr_acc_stall", 32'(cpu_stall), 1);
    tick();
    chk("wr_done_iow",   32'(io_write),  0);
    chk("wr_done_stall", 32'(cpu_stall), 0);
    tick();
    idle(); #1;
    chk("wr_idle_iow",   32'(io_write),  0);
    chk("wr_idle_stall", 32'(cpu_stall), 0);

    // I/O read with 3 wait cycles; store data must not reach the bus
    cpu_read = 1'b1; cpu_addr = 32'hFFFF_FF10; cpu_wdata = 32'hC3; #1;
    chk("rd_req_stall", 32'(cpu_stall), 1);
    tick();
    slave_drv = 1'b1; slave_val = 8'h3C; #1;
    chk("rd_a1_ior",   32'(io_read),   1);
    chk("rd_a1_iow",   32'(io_write),  0);
    chk("rd_a1_addr",  32'(io_addr),   32'h10);
    chk("rd_a1_bus",   32'(io_data),   32'h3C);
    chk("rd_a1_stall", 32'(cpu_stall), 1);
    tick();
    chk("rd_a2_stall", 32'(cpu_stall), 1);
    tick();
    chk("rd_a3_stall", 32'(cpu_stall), 1);
    tick();
    io_ready = 1'b1; slave_val = 8'h5A; #1;
    chk("rd_a4_stall", 32'(cpu_stall), 1);
    tick();
    io_ready = 1'b0; slave_val = 8'h3C; #1;
    chk("rd_done_rdata", cpu_rdata,      32'h0000_005A);
    chk("rd_done_stall", 32'(cpu_stall), 0);
    chk("rd_done_ior",   32'(io_read),   0);
    chk("rd_done_bus",   32'(io_data),   32'h3C);
    tick();
    idle();

    // Back-to-back: simultaneous read+write to I/O accepted in the next IDLE
    cpu_read = 1'b1; cpu_write = 1'b1; cpu_addr = 32'hFFFF_FF40; cpu_wdata = 32'h12;
    io_ready = 1'b1; #1;
    chk("rw_req_stall", 32'(cpu_stall), 1);
    chk("rw_req_memw",  32'(mem_write), 0);
    chk("rw_req_memr",  32'(mem_read),  0);
    tick();
    chk("rw_iow",  32'(io_write), 1);
    chk("rw_ior",  32'(io_read),  0);
    chk("rw_data", 32'(io_data),  32'h12);
    tick();
    chk("rw_done_stall", 32'(cpu_stall), 0);
    tick();
    idle();

`ifdef IO_BRIDGE_TIMEOUT_EN
    // Timeout: io_ready never rises
    cpu_read = 1'b1; cpu_addr = 32'hFFFF_FF04; #1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("tmo_acc_stall", 32'(cpu_stall), 1);
    end
    tick();
    chk("tmo_rdata", cpu_rdata,      32'hFFFF_FFFF);
    chk("tmo_err",   32'(bus_error), 1);
    chk("tmo_stall", 32'(cpu_stall), 0);
    tick();
    idle();
    cpu_write = 1'b1; cpu_addr = 32'hFFFF_FF08; cpu_wdata = 32'h55; io_ready = 1'b1; #1;
    tick();
    tick();
    chk("tmo_err_sticky", 32'(bus_error), 1);
    tick();
    idle();
`else
    // Without the timeout a long wait still completes and no error is flagged
    cpu_read = 1'b1; cpu_addr = 32'hFFFF_FF04; #1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("long_acc_stall", 32'(cpu_stall), 1);
    end
    io_ready = 1'b1; slave_drv = 1'b1; slave_val = 8'h99;
    tick();
    chk("long_rdata", cpu_rdata,      32'h99);
    chk("long_err",   32'(bus_error), 0);
    tick();
    idle();
`endif

    // Async reset in the middle of an I/O write
    cpu_write = 1'b1; cpu_addr = 32'hFFFF_FF20; cpu_wdata = 32'hC3; #1;
    tick();
    chk("rr_iow", 32'(io_write), 1);
    #2;
    rst = 1'b1;
    #1;
    slave_drv = 1'b1; slave_val = 8'h3C; #1;
    chk("rr_iow_drop", 32'(io_write), 0);
    chk("rr_bus",      32'(io_data),  32'h3C);
    chk("rr_ioaddr",   32'(io_addr),  0);
    idle(); #2;
    rst = 1'b0;
    tick();
    mem_rdata = 32'hCAFE_0001; #1;
    chk("rr_idle_stall", 32'(cpu_stall), 0);
    chk("rr_idle_rdata", cpu_rdata,      32'hCAFE_0001);
    cpu_read = 1'b1; cpu_addr = 32'hFFFF_FF30; io_ready = 1'b1;
    slave_drv = 1'b1; slave_val = 8'h77; #1;
    chk("rr2_stall", 32'(cpu_stall), 1);
    tick();
    chk("rr2_ior", 32'(io_read), 1);
    tick();
    chk("rr2_rdata", cpu_rdata,      32'h77);
    chk("rr2_stall_done", 32'(cpu_stall), 0);
    tick();
    idle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
